convolution_controller: RTL and testbench
=========================================

Name: convolution_controller

Overview:
- AXI-controlled 2-D convolution sequencer. It accepts a raster image pixel-by-pixel on an AXI4-Stream slave and buffers the last KERNEL_SIZE rows.
- For every valid KxK window it presents window pixels and filter coefficients to an external multiply-accumulate array. It then forwards that array's sum (cSum/cReady) on an AXI4-Stream master.
- Filter, image size, enable and soft reset are programmed through a simplified AXI4-Lite slave.

Parameters:
- DATA_WIDTH, 8: pixel, coefficient, register and stream data width.
- KERNEL_SIZE, 3: square kernel dimension K.
- AXI_ADDR_WIDTH, 10: register address width (byte addresses).
- MAX_WIDTH, 256: maximum image width; sets line-buffer depth.

Ports:
- axi_clk  in  1  single clock, all logic on rising edge.
- axi_reset  in  1  reset; asynchronous, active-high.
- cSum  in  DATA_WIDTH  accumulated window result from MAC array.
- cReady  in  1  one-cycle pulse, cSum valid.
- MULTIPLIER_INPUT  out  K*K*DATA_WIDTH  window pixels, element i*K+j (row i, col j) at bits [(i*K+j)*DW +: DW].
- MULTIPLICAND_INPUT  out  K*K*DATA_WIDTH  filter coefficients, same packing.
- MULTIPLY_START  out  K*K  per-element start pulse.
- s_axis_valid/s_axis_data[DW]/s_axis_ready(out)/s_axis_last/s_axis_keep[DW/8]  input pixel stream.
- m_axis_valid(out)/m_axis_data(out,DW)/m_axis_ready(in)/m_axis_last(out)/m_axis_keep(out,DW/8)  result stream.
- s_axi_awaddr in AW, s_axi_awready out, s_axi_awvalid in, s_axi_wdata in DW, s_axi_wready out, s_axi_wvalid in  write channel.
- s_axi_araddr in AW, s_axi_arready out, s_axi_arvalid in, s_axi_rdata out DW, s_axi_rready in, s_axi_rvalid out  read channel.
- s_axi_bvalid out, s_axi_bready in  write response.

Behaviour:
- Reset: all outputs 0, all registers 0, line buffer pointers 0. Reset is asynchronous.
- Register map (byte addresses):
  - 0 CTRL: bit0 enable.
  - 4 SOFTRST: write 1 self-clears next cycle and clears CTRL, WIDTH, HEIGHT and stream state. Filter registers are kept.
  - 8 STATUS (RO): bit0 busy, bit1 done.
  - 16 WIDTH.
  - 20 HEIGHT.
  - 24+4k FILTER[k], k = 0..K*K-1.
  - Other addresses: writes ignored, reads return 0.
- Write: awready = wready = 1 while bvalid is low. A write is committed in the cycle where awvalid & wvalid & ready are all high. bvalid asserts the next cycle and holds until bready.
- Read: arready = 1 while rvalid is low. rdata/rvalid are registered the cycle after arvalid and held until rready.
- s_axis_ready = enable & not done & controller in IDLE state.
- Each accepted pixel is written to the line buffer at (row mod K, col). col wraps at WIDTH and row increments on wrap. s_axis_last and s_axis_keep are ignored; position is counted from WIDTH/HEIGHT.
- FSM: IDLE -> MULT -> WAIT -> OUT -> IDLE.
  - IDLE -> MULT when an accepted pixel has row >= K-1 and col >= K-1.
  - MULT (1 cycle):
    - MULTIPLIER_INPUT = window rows row-K+1..row, cols col-K+1..col, including the current pixel.
    - MULTIPLICAND_INPUT = FILTER[i*K+j].
    - MULTIPLY_START = all ones for exactly this cycle.
  - WAIT: hold inputs until cReady. Latch cSum.
  - OUT: m_axis_valid = 1, m_axis_data = latched cSum, m_axis_keep = all ones. Held until m_axis_ready. m_axis_last = 1 on the final window (row = HEIGHT-1, col = WIDTH-1).
  - Pixels not completing a window leave the FSM in IDLE (one pixel per cycle).
- After the last pixel is accepted and the last result is sent: done = 1 and s_axis_ready = 0 until soft reset or disable.
- Output count = (WIDTH-K+1)*(HEIGHT-K+1). WIDTH < K or HEIGHT < K gives no outputs; done is set after WIDTH*HEIGHT pixels.
- Clearing enable mid-frame stalls input only. A transfer in OUT still completes.
- Soft reset mid-frame abandons the frame. m_axis_valid drops the cycle after the write is committed.
- A register write and a stream transfer in the same cycle are both honoured. WIDTH/HEIGHT changes mid-frame are undefined and must not be made by software.

Test Plan:
- Register writes/reads: WIDTH=5, HEIGHT=20, FILTER[8]=8 -> readback 5/20/8; bvalid one cycle after each write.
- 5x5 image, pixel = c+5r, FILTER[k]=k, behavioural MAC returning the dot product mod 256 after 2 cycles -> 9 outputs. Unwrapped dot products are 312, 348, 384, 492, 528, 564, 672, 708, 744; delivered values are those mod 256 (56, 92, 128, 236, 16, 52, 160, 196, 232). m_axis_last only on the 9th.
- MULT cycle of the first window -> MULTIPLIER_INPUT elements 0,1,2,5,6,7,10,11,12; MULTIPLY_START = 9'h1FF for exactly 1 cycle.
- Hold m_axis_ready low 5 cycles during the second output -> data stable, s_axis_ready low, no pixel lost.
- Soft reset (write 1 to addr 4) mid-frame -> m_axis_valid/s_axis_ready drop, CTRL reads 0; re-enable plus full frame gives the same 9 results.
- enable = 0 -> s_axis_ready stays 0 with s_axis_valid high.

Source files
------------

// File: rtl/convolution_controller_if.sv
// Bus bundle for the convolution controller: pixel stream in, result stream out,
// and the simplified AXI4-Lite register port.
interface convolution_controller_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int AXI_ADDR_WIDTH = 10
);
    localparam int KEEP_W = DATA_WIDTH / 8;

    // Every channel transfers on the rising edge where valid and ready are both
    // high; valid never waits on ready, and payload is held stable while valid
    // is high and ready is low.
    logic                      s_axis_valid;
    logic [DATA_WIDTH-1:0]     s_axis_data;
    logic                      s_axis_ready;
    logic                      s_axis_last;
    logic [KEEP_W-1:0]         s_axis_keep;

    logic                      m_axis_valid;
    logic [DATA_WIDTH-1:0]     m_axis_data;
    logic                      m_axis_ready;
    logic                      m_axis_last;
    logic [KEEP_W-1:0]         m_axis_keep;

    logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                      s_axi_awready;
    logic                      s_axi_awvalid;
    logic [DATA_WIDTH-1:0]     s_axi_wdata;
    logic                      s_axi_wready;
    logic                      s_axi_wvalid;
    logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr;
    logic                      s_axi_arready;
    logic                      s_axi_arvalid;
    logic [DATA_WIDTH-1:0]     s_axi_rdata;
    logic                      s_axi_rready;
    logic                      s_axi_rvalid;
    logic                      s_axi_bvalid;
    logic                      s_axi_bready;

    modport slave (
        input  s_axis_valid, s_axis_data, s_axis_last, s_axis_keep,
        output s_axis_ready,
        output m_axis_valid, m_axis_data, m_axis_last, m_axis_keep,
        input  m_axis_ready,
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid,
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready, s_axi_bready,
        output s_axi_awready, s_axi_wready, s_axi_arready,
        output s_axi_rdata, s_axi_rvalid, s_axi_bvalid
    );

    modport master (
        output s_axis_valid, s_axis_data, s_axis_last, s_axis_keep,
        input  s_axis_ready,
        input  m_axis_valid, m_axis_data, m_axis_last, m_axis_keep,
        output m_axis_ready,
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid,
        output s_axi_araddr, s_axi_arvalid, s_axi_rready, s_axi_bready,
        input  s_axi_awready, s_axi_wready, s_axi_arready,
        input  s_axi_rdata, s_axi_rvalid, s_axi_bvalid
    );
endinterface

// File: rtl/convolution_controller.sv
// 2-D convolution sequencer: buffers the last K image rows, hands each KxK window
// to an external MAC array and streams the returned sums out.
module convolution_controller #(
    parameter int DATA_WIDTH     = 8,
    parameter int KERNEL_SIZE    = 3,
    parameter int AXI_ADDR_WIDTH = 10,
    parameter int MAX_WIDTH      = 256
) (
    input  logic                                      axi_clk,
    input  logic                                      axi_reset,
    input  logic [DATA_WIDTH-1:0]                     cSum,
    input  logic                                      cReady,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] MULTIPLIER_INPUT,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] MULTIPLICAND_INPUT,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]        MULTIPLY_START,
    output logic [1:0]                                dbg_state,
    convolution_controller_if.slave                   bus
);
    localparam int K      = KERNEL_SIZE;
    localparam int KK     = K * K;
    localparam int DW     = DATA_WIDTH;
    localparam int AW     = AXI_ADDR_WIDTH;
    localparam int COL_W  = $clog2(MAX_WIDTH);
    localparam int SLOT_W = (K > 1) ? $clog2(K) : 1;
    localparam int IDX_W  = (KK > 1) ? $clog2(KK) : 1;

    localparam logic [AW-1:0] ADDR_CTRL    = AW'(0);
    localparam logic [AW-1:0] ADDR_SOFTRST = AW'(4);
    localparam logic [AW-1:0] ADDR_STATUS  = AW'(8);
    localparam logic [AW-1:0] ADDR_WIDTH   = AW'(16);
    localparam logic [AW-1:0] ADDR_HEIGHT  = AW'(20);
    localparam logic [AW-1:0] FILT_BASE    = AW'(24);
    localparam logic [AW-1:0] FILT_END     = AW'(24 + 4 * KK);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_WAIT, S_OUT} state_t;

    // Register file
    logic          ctrl_en;
    logic          softrst_r;
    logic [DW-1:0] width_r;
    logic [DW-1:0] height_r;
    logic [DW-1:0] filter_r [KK];
    logic          bvalid_r;
    logic          rvalid_r;
    logic [DW-1:0] rdata_r;
    logic [DW-1:0] rd_mux;

    // Stream / window state
    state_t                  state_r, state_nx;
    logic [COL_W-1:0]        col_r;
    logic [DW-1:0]           row_r;
    logic [SLOT_W-1:0]       slot_r;
    logic                    all_in_r;
    logic                    done_r;
    logic                    last_win_r;
    logic [DW-1:0]           sum_r;
    logic [KK*DW-1:0]        mult_in_r;
    logic [KK*DW-1:0]        coef_r;
    logic [KK*DW-1:0]        win_nx;
    logic [KK*DW-1:0]        coef_nx;
    logic [DW-1:0]           line_buf [K][MAX_WIDTH];
    int                      ridx;
    int                      cidx;

    logic wr_fire, rd_fire, soft_clr;
    logic s_ready, pix_fire;
    logic last_col, last_row, frame_end, win_ok;
    logic busy;
    logic unused_inputs;

    function automatic logic is_filter(input logic [AW-1:0] a);
        return (a >= FILT_BASE) && (a < FILT_END) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [IDX_W-1:0] filter_idx(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - FILT_BASE;
        return IDX_W'(off >> 2);
    endfunction

    assign unused_inputs = ^{bus.s_axis_last, bus.s_axis_keep};

    assign wr_fire  = bus.s_axi_awvalid & bus.s_axi_wvalid & ~bvalid_r;
    assign rd_fire  = bus.s_axi_arvalid & ~rvalid_r;
    assign soft_clr = wr_fire && (bus.s_axi_awaddr == ADDR_SOFTRST) && bus.s_axi_wdata[0];

    assign bus.s_axi_awready = ~bvalid_r;
    assign bus.s_axi_wready  = ~bvalid_r;
    assign bus.s_axi_bvalid  = bvalid_r;
    assign bus.s_axi_arready = ~rvalid_r;
    assign bus.s_axi_rvalid  = rvalid_r;
    assign bus.s_axi_rdata   = rdata_r;

    // Register writes; soft reset keeps the filter so software only reloads geometry.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            ctrl_en   <= 1'b0;
            softrst_r <= 1'b0;
            width_r   <= '0;
            height_r  <= '0;
            bvalid_r  <= 1'b0;
            for (int k = 0; k < KK; k++) filter_r[k] <= '0;
        end else begin
            softrst_r <= 1'b0;
            if (bvalid_r && bus.s_axi_bready) bvalid_r <= 1'b0;
            if (wr_fire) begin
                bvalid_r <= 1'b1;
                case (bus.s_axi_awaddr)
                    ADDR_CTRL:   ctrl_en  <= bus.s_axi_wdata[0];
                    ADDR_WIDTH:  width_r  <= bus.s_axi_wdata;
                    ADDR_HEIGHT: height_r <= bus.s_axi_wdata;
                    ADDR_SOFTRST: begin
                        if (bus.s_axi_wdata[0]) begin
                            softrst_r <= 1'b1;
                            ctrl_en   <= 1'b0;
                            width_r   <= '0;
                            height_r  <= '0;
                        end
                    end
                    default: begin
                        if (is_filter(bus.s_axi_awaddr))
                            filter_r[filter_idx(bus.s_axi_awaddr)] <= bus.s_axi_wdata;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.s_axi_araddr)
            ADDR_CTRL:    rd_mux[0] = ctrl_en;
            ADDR_SOFTRST: rd_mux[0] = softrst_r;
            ADDR_STATUS: begin
                rd_mux[0] = busy;
                rd_mux[1] = done_r;
            end
            ADDR_WIDTH:   rd_mux = width_r;
            ADDR_HEIGHT:  rd_mux = height_r;
            default: begin
                if (is_filter(bus.s_axi_araddr)) rd_mux = filter_r[filter_idx(bus.s_axi_araddr)];
            end
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
        end else begin
            if (rvalid_r && bus.s_axi_rready) rvalid_r <= 1'b0;
            if (rd_fire) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_mux;
            end
        end
    end

    // Stream position decode
    assign s_ready   = ctrl_en & ~done_r & (state_r == S_IDLE);
    assign pix_fire  = bus.s_axis_valid & s_ready;
    assign last_col  = (DW'(col_r) == width_r - DW'(1));
    assign last_row  = (row_r == height_r - DW'(1));
    assign frame_end = last_col & last_row;
    assign win_ok    = (row_r >= DW'(K - 1)) && (col_r >= COL_W'(K - 1));
    assign busy      = (state_r != S_IDLE) | (((row_r != '0) | (col_r != '0)) & ~done_r);

    // Window assembly: rows live in slot (row mod K); the newest pixel bypasses the buffer.
    always_comb begin
        win_nx  = '0;
        coef_nx = '0;
        ridx    = 0;
        cidx    = 0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                ridx = int'(slot_r) + 1 + i;
                if (ridx >= K) ridx = ridx - K;
                cidx = int'(col_r) - (K - 1) + j;
                if (i == K - 1 && j == K - 1)
                    win_nx[(i*K+j)*DW +: DW] = bus.s_axis_data;
                else
                    win_nx[(i*K+j)*DW +: DW] = line_buf[SLOT_W'(ridx)][COL_W'(cidx)];
                coef_nx[(i*K+j)*DW +: DW] = filter_r[i*K+j];
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (pix_fire) line_buf[slot_r][col_r] <= bus.s_axis_data;
    end

    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE: if (pix_fire && win_ok) state_nx = S_MULT;
            S_MULT: state_nx = S_WAIT;
            S_WAIT: if (cReady) state_nx = S_OUT;
            S_OUT:  if (bus.m_axis_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state_r    <= S_IDLE;
            col_r      <= '0;
            row_r      <= '0;
            slot_r     <= '0;
            all_in_r   <= 1'b0;
            done_r     <= 1'b0;
            last_win_r <= 1'b0;
            sum_r      <= '0;
            mult_in_r  <= '0;
            coef_r     <= '0;
        end else if (soft_clr) begin
            state_r    <= S_IDLE;
            col_r      <= '0;
            row_r      <= '0;
            slot_r     <= '0;
            all_in_r   <= 1'b0;
            done_r     <= 1'b0;
            last_win_r <= 1'b0;
        end else begin
            state_r <= state_nx;
            if (pix_fire) begin
                if (last_col) begin
                    col_r <= '0;
                    if (last_row) begin
                        row_r  <= '0;
                        slot_r <= '0;
                    end else begin
                        row_r  <= row_r + DW'(1);
                        slot_r <= (slot_r == SLOT_W'(K - 1)) ? '0 : slot_r + SLOT_W'(1);
                    end
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
                if (win_ok) begin
                    last_win_r <= frame_end;
                    mult_in_r  <= win_nx;
                    coef_r     <= coef_nx;
                end
            end
            if (state_r == S_WAIT && cReady) sum_r <= cSum;
            // done waits for the final result to leave; disabling re-arms for a new frame
            if (!ctrl_en && done_r) begin
                done_r   <= 1'b0;
                all_in_r <= 1'b0;
            end else if ((all_in_r || (pix_fire && frame_end)) && state_nx == S_IDLE) begin
                done_r   <= 1'b1;
                all_in_r <= 1'b1;
            end else if (pix_fire && frame_end) begin
                all_in_r <= 1'b1;
            end
        end
    end

    assign MULTIPLIER_INPUT   = mult_in_r;
    assign MULTIPLICAND_INPUT = coef_r;
    assign MULTIPLY_START     = (state_r == S_MULT) ? {KK{1'b1}} : '0;
    assign dbg_state          = state_r;

    assign bus.s_axis_ready = s_ready;
    assign bus.m_axis_valid = (state_r == S_OUT);
    assign bus.m_axis_data  = (state_r == S_OUT) ? sum_r : '0;
    assign bus.m_axis_last  = (state_r == S_OUT) & last_win_r;
    assign bus.m_axis_keep  = (state_r == S_OUT) ? '1 : '0;
endmodule

// File: tb/tb_convolution_controller.sv
// Directed bench for convolution_controller: behavioural MAC, a frame-level result
// model with an expected queue, and literal values that pin the model.
module tb_convolution_controller;
  localparam int DW = 8;
  localparam int K  = 3;
  localparam int KK = 9;
  localparam int AW = 10;

  // clock / reset
  logic axi_clk = 1'b0;
  logic axi_reset;
  always #5 axi_clk = ~axi_clk;

  logic [DW-1:0]    cSum = '0;
  logic             cReady = 1'b0;
  logic [KK*DW-1:0] mul_in;
  logic [KK*DW-1:0] mcand_in;
  logic [KK-1:0]    mstart;
  logic [1:0]       dbg_state;

  convolution_controller_if #(.DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus();

  convolution_controller #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .AXI_ADDR_WIDTH(AW), .MAX_WIDTH(256)
  ) dut (
    .axi_clk(axi_clk),
    .axi_reset(axi_reset),
    .cSum(cSum),
    .cReady(cReady),
    .MULTIPLIER_INPUT(mul_in),
    .MULTIPLICAND_INPUT(mcand_in),
    .MULTIPLY_START(mstart),
    .dbg_state(dbg_state),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // model state
  int img [20][20];
  int filt [KK];
  logic [DW-1:0] exp_q[$];
  logic exp_last_q[$];
  logic [DW-1:0] rx_data [64];
  logic rx_last [64];
  int rx_cnt = 0;
  int lit [9] = '{56, 92, 128, 236, 16, 52, 160, 196, 232};
  int first_win [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

  logic sink_hold = 1'b0;
  logic stall_armed = 1'b0;
  int stall_cnt = 0;
  logic first_win_pending = 1'b0;
  logic prev_start = 1'b0;

  function automatic void load_image(input int w, input int h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        img[r][c] = (c + w * r) % 256;
  endfunction

  function automatic void build_expected(input int w, input int h);
    int s;
    for (int r = K - 1; r < h; r++)
      for (int c = K - 1; c < w; c++) begin
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += img[r-K+1+i][c-K+1+j] * filt[i*K+j];
        exp_q.push_back(DW'(s % 256));
        exp_last_q.push_back((r == h - 1) && (c == w - 1));
      end
  endfunction

  // behavioural MAC: dot product, returned mod 256 two cycles after start
  int mac_cnt = 0;
  logic [31:0] mac_acc;
  always @(posedge axi_clk) begin
    if (mstart != '0) begin
      mac_acc = 0;
      for (int k = 0; k < KK; k++)
        mac_acc += 32'(mul_in[k*DW +: DW]) * 32'(mcand_in[k*DW +: DW]);
      mac_cnt = 2;
      cReady <= 1'b0;
    end else if (mac_cnt > 0) begin
      mac_cnt--;
      cReady <= (mac_cnt == 0);
      if (mac_cnt == 0) cSum <= mac_acc[7:0];
    end else begin
      cReady <= 1'b0;
    end
  end

  // result sink: optional long hold, plus a 5-cycle stall on the second output
  initial begin
    bus.m_axis_ready = 1'b1;
    forever begin
      @(posedge axi_clk);
      #1;
      if (sink_hold) bus.m_axis_ready = 1'b0;
      else if (stall_armed && bus.m_axis_valid && rx_cnt == 1) begin
        if (stall_cnt < 5) begin
          bus.m_axis_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.m_axis_ready = 1'b1;
          stall_armed = 1'b0;
        end
      end else bus.m_axis_ready = 1'b1;
    end
  end

  // scoreboard / compare process
  always @(negedge axi_clk) begin
    logic [KK*DW-1:0] coef_exp;
    logic [DW-1:0] e;
    logic el;
    if (!axi_reset) begin
      if (bus.m_axis_valid && bus.m_axis_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 72'(bus.m_axis_data), 72'hFFFF);
        end else begin
          e = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check("out_data", 72'(bus.m_axis_data), 72'(e));
          check("out_last", 72'(bus.m_axis_last), 72'(el));
          check("out_keep", 72'(bus.m_axis_keep), 72'(1));
        end
        if (rx_cnt < 64) begin
          rx_data[rx_cnt] = bus.m_axis_data;
          rx_last[rx_cnt] = bus.m_axis_last;
        end
        rx_cnt++;
      end else if (bus.m_axis_valid && !bus.m_axis_ready && !sink_hold) begin
        if (exp_q.size() == 0) check("stall_no_expect", 72'(bus.m_axis_data), 72'hFFFF);
        else check("stall_data_stable", 72'(bus.m_axis_data), 72'(exp_q[0]));
        check("stall_s_ready_low", 72'(bus.s_axis_ready), 72'(0));
      end
      if (mstart != '0) begin
        coef_exp = '0;
        for (int k = 0; k < KK; k++) coef_exp[k*DW +: DW] = DW'(filt[k]);
        check("mult_start", 72'(mstart), 72'h1FF);
        check("mult_start_single", 72'(prev_start), 72'(0));
        check("multiplicand", 72'(mcand_in), 72'(coef_exp));
        if (first_win_pending) begin
          for (int k = 0; k < KK; k++)
            check("first_window_el", 72'(mul_in[k*DW +: DW]), 72'(first_win[k]));
          first_win_pending = 1'b0;
        end
      end
      prev_start = (mstart != '0);
    end
  end

  // driver tasks
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int guard;
    @(posedge axi_clk); #1;
    bus.s_axi_awaddr = addr;
    bus.s_axi_wdata = data;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid = 1'b1;
    guard = 0;
    while (!(bus.s_axi_awready && bus.s_axi_wready) && guard < 50) begin
      @(posedge axi_clk); #1;
      guard++;
    end
    if (guard >= 50) check("write_timeout", 72'(guard), 72'(0));
    @(posedge axi_clk); #1;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid = 1'b0;
    check("bvalid_after_write", 72'(bus.s_axi_bvalid), 72'(1));
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    int guard;
    @(posedge axi_clk); #1;
    bus.s_axi_araddr = addr;
    bus.s_axi_arvalid = 1'b1;
    guard = 0;
    while (!bus.s_axi_arready && guard < 50) begin
      @(posedge axi_clk); #1;
      guard++;
    end
    if (guard >= 50) check("read_timeout", 72'(guard), 72'(0));
    @(posedge axi_clk); #1;
    bus.s_axi_arvalid = 1'b0;
    check("rvalid_after_read", 72'(bus.s_axi_rvalid), 72'(1));
    data = bus.s_axi_rdata;
  endtask

  task automatic send_pixels(input int w, input int n);
    int guard;
    for (int p = 0; p < n; p++) begin
      bus.s_axis_valid = 1'b1;
      bus.s_axis_data = DW'(img[p / w][p % w]);
      guard = 0;
      while (!bus.s_axis_ready && guard < 400) begin
        @(posedge axi_clk); #1;
        guard++;
      end
      if (guard >= 400) begin
        check("pixel_timeout", 72'(p), 72'hFFFF);
        break;
      end
      @(posedge axi_clk); #1;
    end
    bus.s_axis_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int guard;
    guard = 0;
    while (rx_cnt < target && guard < 2000) begin
      @(posedge axi_clk); #1;
      guard++;
    end
    if (guard >= 2000) check("result_timeout", 72'(rx_cnt), 72'(target));
  endtask

  task automatic setup_frame(input int w, input int h);
    logic [DW-1:0] rd;
    axi_write(AW'(16), DW'(w));
    axi_write(AW'(20), DW'(h));
    axi_write(AW'(0), DW'(1));
    axi_read(AW'(0), rd);
    check("ctrl_enabled", 72'(rd), 72'(1));
  endtask

  task automatic check_literals(input string tag);
    int lasts;
    lasts = 0;
    for (int i = 0; i < 9; i++) begin
      check({tag, "_result"}, 72'(rx_data[i]), 72'(lit[i]));
      if (rx_last[i]) lasts++;
    end
    check({tag, "_last_on_ninth"}, 72'(rx_last[8]), 72'(1));
    check({tag, "_last_count"}, 72'(lasts), 72'(1));
  endtask

  initial begin
    logic [DW-1:0] rd;
    int guard;
    bus.s_axis_valid = 1'b0;
    bus.s_axis_data = '0;
    bus.s_axis_last = 1'b0;
    bus.s_axis_keep = 1'b1;
    bus.s_axi_awaddr = '0;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0;
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_araddr = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b1;
    bus.s_axi_bready = 1'b1;
    axi_reset = 1'b1;
    repeat (3) @(posedge axi_clk);
    #1;
    check("rst_m_valid", 72'(bus.m_axis_valid), 72'(0));
    check("rst_s_ready", 72'(bus.s_axis_ready), 72'(0));
    check("rst_bvalid", 72'(bus.s_axi_bvalid), 72'(0));
    check("rst_rvalid", 72'(bus.s_axi_rvalid), 72'(0));
    check("rst_mstart", 72'(mstart), 72'(0));
    check("rst_mul_in", 72'(mul_in), 72'(0));
    check("rst_state", 72'(dbg_state), 72'(0));
    axi_reset = 1'b0;

    // register map
    axi_write(AW'(16), DW'(5));
    axi_write(AW'(20), DW'(20));
    axi_write(AW'(56), DW'(8));
    axi_read(AW'(16), rd);  check("rd_width", 72'(rd), 72'(5));
    axi_read(AW'(20), rd);  check("rd_height", 72'(rd), 72'(20));
    axi_read(AW'(56), rd);  check("rd_filter8", 72'(rd), 72'(8));
    axi_read(AW'(100), rd); check("rd_unmapped", 72'(rd), 72'(0));

    // 5x5 frame with a 5-cycle stall on the second result
    for (int k = 0; k < KK; k++) begin
      filt[k] = k;
      axi_write(AW'(24 + 4 * k), DW'(k));
    end
    load_image(5, 5);
    build_expected(5, 5);
    check("model_count", 72'(exp_q.size()), 72'(9));
    setup_frame(5, 5);
    stall_armed = 1'b1;
    first_win_pending = 1'b1;
    send_pixels(5, 25);
    wait_rx(9);
    repeat (3) @(posedge axi_clk);
    #1;
    check_literals("frame1");
    check("frame1_queue_empty", 72'(exp_q.size()), 72'(0));
    check("stall_seen", 72'(stall_cnt), 72'(5));
    check("done_blocks_input", 72'(bus.s_axis_ready), 72'(0));
    axi_read(AW'(8), rd); check("status_done", 72'(rd), 72'(2));

    // disabled controller refuses pixels
    axi_write(AW'(0), DW'(0));
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data = 8'hAA;
    for (int i = 0; i < 6; i++) begin
      @(posedge axi_clk); #1;
      check("disabled_s_ready", 72'(bus.s_axis_ready), 72'(0));
    end
    bus.s_axis_valid = 1'b0;
    axi_read(AW'(8), rd); check("status_cleared", 72'(rd), 72'(0));

    // soft reset mid-frame while a result is held
    rx_cnt = 0;
    axi_write(AW'(0), DW'(1));
    sink_hold = 1'b1;
    send_pixels(5, 13);
    guard = 0;
    while (!bus.m_axis_valid && guard < 50) begin
      @(posedge axi_clk); #1;
      guard++;
    end
    check("held_output_present", 72'(bus.m_axis_valid), 72'(1));
    axi_write(AW'(4), DW'(1));
    check("softrst_m_valid_drop", 72'(bus.m_axis_valid), 72'(0));
    check("softrst_s_ready_drop", 72'(bus.s_axis_ready), 72'(0));
    sink_hold = 1'b0;
    axi_read(AW'(0), rd);  check("softrst_ctrl", 72'(rd), 72'(0));
    axi_read(AW'(16), rd); check("softrst_width", 72'(rd), 72'(0));
    axi_read(AW'(56), rd); check("softrst_filter_kept", 72'(rd), 72'(8));
    check("abandoned_no_output", 72'(rx_cnt), 72'(0));

    // full frame again after soft reset
    build_expected(5, 5);
    setup_frame(5, 5);
    send_pixels(5, 25);
    wait_rx(9);
    repeat (3) @(posedge axi_clk);
    #1;
    check_literals("frame2");
    check("frame2_queue_empty", 72'(exp_q.size()), 72'(0));

    // image narrower than the kernel: no outputs, done after all pixels
    axi_write(AW'(0), DW'(0));
    load_image(2, 2);
    setup_frame(2, 2);
    send_pixels(2, 4);
    repeat (10) @(posedge axi_clk);
    #1;
    axi_read(AW'(8), rd); check("small_status_done", 72'(rd), 72'(2));
    check("small_no_output", 72'(rx_cnt), 72'(9));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
